pyramid_gen_param: RTL

//  Parametrised streaming image-pyramid generator for the pyramidal LK flow path. Accepts one

---
 rtl/pyramid_gen_param_if.sv | 23 ++
 rtl/pyramid_gen_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pyramid_gen_param_if.sv
// Pixel stream interface for pyramid_gen_param.
// The master drives the input stream; the slave (the generator) drives the per-level outputs.
interface pyramid_gen_param_if #(
  parameter int NUM_LEVELS = 3,
  parameter int IN_W       = 12,
  parameter int OUT_W      = 8
);
  logic                        addr_en;
  logic [IN_W-1:0]             pixel_in;
  logic [NUM_LEVELS*OUT_W-1:0] pixout;
  logic [NUM_LEVELS-1:0]       w_en;
  logic                        frame_done;

  modport master (
    output addr_en, pixel_in,
    input  pixout, w_en, frame_done
  );

  modport slave (
    input  addr_en, pixel_in,
    output pixout, w_en, frame_done
  );
endinterface

// File: rtl/pyramid_gen_param.sv
// Streaming image-pyramid generator.
// Level 0 is the input truncated to OUT_W bits; each deeper level is a 2x2 reduction
// (rounded box average or odd/odd decimation) of the level above, produced on the fly
// from that level's write strobes. Each level k>=1 keeps one line buffer of horizontal
// pair sums for the even row; on the odd row the matching sum is prefetched one pixel
// early so the buffer behaves as a RAM with registered read.
module pyramid_gen_param #(
  parameter int NUM_LEVELS = 3,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int IN_W       = 12,
  parameter int OUT_W      = 8,
  parameter int MODE       = 0
) (
  input logic               clk,
  input logic               reset,
  pyramid_gen_param_if.slave bus
);

  localparam int DIV = 1 << ((NUM_LEVELS > 0) ? (NUM_LEVELS - 1) : 0);

  if (NUM_LEVELS < 1 || NUM_LEVELS > 4) begin : g_bad_levels
    $error("pyramid_gen_param: NUM_LEVELS must be in 1..4");
  end
  if ((IMG_W % DIV) != 0 || (IMG_H % DIV) != 0) begin : g_bad_dims
    $error("pyramid_gen_param: IMG_W and IMG_H must be divisible by 2^(NUM_LEVELS-1)");
  end
  if (IN_W < OUT_W) begin : g_bad_width
    $error("pyramid_gen_param: IN_W must be >= OUT_W");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("pyramid_gen_param: MODE must be 0 or 1");
  end

  // Per-level output pixel and strobe, each slice driven by its own level block.
  wire [NUM_LEVELS*OUT_W-1:0] lvl_pix;
  wire [NUM_LEVELS-1:0]       lvl_en;
  // High on the strobe that completes the deepest level's frame.
  logic                       frame_last;
  logic                       frame_done_reg;

  for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_lvl
    logic [OUT_W-1:0] pix_reg;
    logic             en_reg;

    assign lvl_pix[gi*OUT_W +: OUT_W] = pix_reg;
    assign lvl_en[gi]                 = en_reg;

    if (gi == 0) begin : g_l0
      // Level 0: keep the top OUT_W bits of each accepted pixel, no rounding.
      always_ff @(posedge clk) begin
        if (reset) begin
          pix_reg <= '0;
          en_reg  <= 1'b0;
        end else begin
          en_reg <= bus.addr_en;
          if (bus.addr_en) begin
            pix_reg <= OUT_W'(bus.pixel_in >> (IN_W - OUT_W));
          end
        end
      end

      // With a single level the frame end is tracked on the input stream itself.
      if (NUM_LEVELS == 1) begin : g_cnt
        localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
        localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
        localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
        localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
        logic [CW-1:0] col_reg;
        logic [RW-1:0] row_reg;

        // Raster position of the next accepted input pixel.
        always_ff @(posedge clk) begin
          if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
          end else if (bus.addr_en) begin
            if (col_reg == COL_LAST) begin
              col_reg <= '0;
              row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end

        assign frame_last = bus.addr_en && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
      end
    end else begin : g_lk
      // Geometry of the level gi-1 stream consumed here.
      localparam int W_IN = IMG_W >> (gi - 1);
      localparam int H_IN = IMG_H >> (gi - 1);
      localparam int CW   = (W_IN > 1) ? $clog2(W_IN) : 1;
      localparam int RW   = (H_IN > 1) ? $clog2(H_IN) : 1;
      localparam logic [CW-1:0] COL_LAST = CW'(W_IN - 1);
      localparam logic [RW-1:0] ROW_LAST = RW'(H_IN - 1);

      logic [OUT_W-1:0] in_pix;
      logic             in_en;
      logic [CW-1:0]    col_reg;
      logic [RW-1:0]    row_reg;
      logic             odd_pos;
      logic [OUT_W-1:0] result;

      assign in_pix  = lvl_pix[(gi-1)*OUT_W +: OUT_W];
      assign in_en   = lvl_en[gi-1];
      // Dimensions are even, so the odd/odd pixel closes each 2x2 block.
      assign odd_pos = row_reg[0] & col_reg[0];

      // Raster position of the incoming level gi-1 pixel.
      always_ff @(posedge clk) begin
        if (reset) begin
          col_reg <= '0;
          row_reg <= '0;
        end else if (in_en) begin
          if (col_reg == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
      end

      if (MODE == 0) begin : g_avg
        localparam int LB_D = W_IN / 2;
        localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

        logic [OUT_W:0]   lb_mem [LB_D];
        logic [OUT_W:0]   lb_rd_reg;
        logic [OUT_W-1:0] even_reg;
        logic [OUT_W:0]   pair_sum;
        logic [AW-1:0]    lb_addr;

        assign lb_addr  = AW'(col_reg >> 1);
        assign pair_sum = {1'b0, even_reg} + {1'b0, in_pix};
        // Four-pixel sum plus 2 fits OUT_W+2 bits and its quarter never exceeds 2^OUT_W-1.
        assign result   = OUT_W'(({1'b0, lb_rd_reg} + {1'b0, pair_sum} + 2'd2) >> 2);

        // Even row: store pair sums. Odd row: fetch the upper pair on the even column
        // so it is registered and ready when the odd column completes the block.
        always_ff @(posedge clk) begin
          if (in_en && !row_reg[0] && col_reg[0]) begin
            lb_mem[lb_addr] <= pair_sum;
          end
          if (in_en && row_reg[0] && !col_reg[0]) begin
            lb_rd_reg <= lb_mem[lb_addr];
          end
        end

        // Hold the even-column pixel until its odd-column partner arrives.
        always_ff @(posedge clk) begin
          if (reset) begin
            even_reg <= '0;
          end else if (in_en && !col_reg[0]) begin
            even_reg <= in_pix;
          end
        end
      end else begin : g_dec
        assign result = in_pix;
      end

      // Register the reduced pixel on the strobe that completes its 2x2 block.
      always_ff @(posedge clk) begin
        if (reset) begin
          pix_reg <= '0;
          en_reg  <= 1'b0;
        end else begin
          en_reg <= in_en & odd_pos;
          if (in_en & odd_pos) begin
            pix_reg <= result;
          end
        end
      end

      if (gi == NUM_LEVELS - 1) begin : g_last
        assign frame_last = in_en && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
      end
    end
  end

  // Frame end is registered alongside the deepest level's final strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_last;
    end
  end

  assign bus.pixout     = lvl_pix;
  assign bus.w_en       = lvl_en;
  assign bus.frame_done = frame_done_reg;

endmodule
